// File: rtl/ram_matrix_reader.sv
// Streams one ROWSxCOLS frame out of the matrix buffer RAM in row-major order as a
// valid/ready pixel stream tagged with row/col/eol/last; a 2-entry skid FIFO absorbs stalls.
module ram_matrix_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BASE   = 0,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ROW_W-1:0]  m_row,
    output logic [COL_W-1:0]  m_col,
    output logic              m_eol,
    output logic              m_last
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               pop_c;
    logic               issue_c;
    logic               rd_end_c;
    logic               done_c;
    logic               in_eol_c;
    logic               in_last_c;
    logic               skid_eol_c;
    logic               skid_last_c;
    logic [1:0]         occ_c;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic               inflight;
    logic [ROW_W-1:0]   fl_row;
    logic [COL_W-1:0]   fl_col;
    logic               skid_valid;
    logic [DATA_W-1:0]  skid_data;
    logic [ROW_W-1:0]   skid_row;
    logic [COL_W-1:0]   skid_col;

    // Occupancy counts what will sit in the FIFO after this edge, so a read may
    // be issued in the same cycle the head drains and full rate is sustained.
    always_comb begin
        pop_c       = m_valid & m_ready;
        occ_c       = 2'(m_valid) + 2'(skid_valid) + 2'(inflight) - 2'(pop_c);
        rd_end_c    = (rd_row == LAST_ROW) && (rd_col == LAST_COL);
        issue_c     = (state_q == READ) && (occ_c < 2'd2);
        done_c      = (state_q == DRAIN) && pop_c && m_last;
        in_eol_c    = (fl_col == LAST_COL);
        in_last_c   = (fl_row == LAST_ROW) && in_eol_c;
        skid_eol_c  = (skid_col == LAST_COL);
        skid_last_c = (skid_row == LAST_ROW) && skid_eol_c;
        state_d     = state_q;
        case (state_q)
            IDLE:    if (start && !done) state_d = READ;
            READ:    if (issue_c && rd_end_c) state_d = DRAIN;
            DRAIN:   if (done_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Read issue, pixel index walk and frame status; busy covers the done cycle
    // so a start coinciding with done is not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_wr   <= 1'b1;
            ram_addr <= ADDR_W'(BASE);
            rd_row   <= '0;
            rd_col   <= '0;
            inflight <= 1'b0;
            fl_row   <= '0;
            fl_col   <= '0;
        end else begin
            ram_wr   <= 1'b1;
            busy     <= (state_d != IDLE) || done_c;
            done     <= done_c;
            inflight <= issue_c;
            if (issue_c) begin
                fl_row <= rd_row;
                fl_col <= rd_col;
            end
            if (state_q != READ) begin
                ram_addr <= ADDR_W'(BASE);
                rd_row   <= '0;
                rd_col   <= '0;
            end else if (issue_c && !rd_end_c) begin
                ram_addr <= ram_addr + ADDR_W'(1);
                if (rd_col == LAST_COL) begin
                    rd_col <= '0;
                    rd_row <= rd_row + ROW_W'(1);
                end else begin
                    rd_col <= rd_col + COL_W'(1);
                end
            end
        end
    end

    // Two-entry FIFO: the head is the output register, the skid entry holds overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_row      <= '0;
            m_col      <= '0;
            m_eol      <= 1'b0;
            m_last     <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_row   <= '0;
            skid_col   <= '0;
        end else begin
            if (m_valid && skid_valid) begin
                if (pop_c) begin
                    m_data <= skid_data;
                    m_row  <= skid_row;
                    m_col  <= skid_col;
                    m_eol  <= skid_eol_c;
                    m_last <= skid_last_c;
                    if (inflight) begin
                        skid_data <= ram_dout;
                        skid_row  <= fl_row;
                        skid_col  <= fl_col;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end
            end else if (inflight && (!m_valid || pop_c)) begin
                m_valid <= 1'b1;
                m_data  <= ram_dout;
                m_row   <= fl_row;
                m_col   <= fl_col;
                m_eol   <= in_eol_c;
                m_last  <= in_last_c;
            end else if (inflight) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_dout;
                skid_row   <= fl_row;
                skid_col   <= fl_col;
            end else if (pop_c) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_matrix_reader.sv
// Bench for ram_matrix_reader: frame scenarios from a table plus hand-written corner
// sequences, every beat compared against a queue-based model of the frame.
module tb_ram_matrix_reader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NPIX   = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        m_row;
    logic [2:0]        m_col;
    logic              m_eol;
    logic              m_last;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] row;
        logic [2:0] col;
        logic       eol;
        logic       last;
    } beat_t;

    typedef struct {
        int mode;
        int pattern;
        int exp_beats;
        int exp_first;
        int exp_last;
        int exp_first_lat;
        int exp_done_lat;
    } vec_t;

    logic [7:0] mem [NPIX];
    logic [4:0] lfsr = 5'h1F;
    int errors = 0;
    int checks = 0;

    ram_matrix_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_eol    (m_eol),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: dout valid one cycle after the address.
    always @(posedge clk) ram_dout <= mem[ram_addr];

    task automatic check(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic get_ready(input int mode, output logic r);
        case (mode)
            0: r = 1'b1;
            1: begin
                r    = lfsr[0];
                lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
            end
            default: r = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic fill(input int pattern);
        for (int i = 0; i < int'(NPIX); i++) begin
            if (pattern == 2) mem[i] = 8'($urandom);
            else              mem[i] = 8'(i - 32);
        end
        if (pattern == 1) begin
            mem[0]      = 8'h80;
            mem[NPIX-1] = 8'h7F;
        end
    endtask

    // Caller is just past a negedge; c counts posedges after the one sampling start.
    task automatic run_frame(input int mode, input int sa, input int sb, input int rst_after,
                             input bit start_at_done, output int nbeats, output int first_lat,
                             output int done_lat, output int ndone, output int first_data,
                             output int last_data);
        beat_t exp_q[$];
        beat_t act;
        beat_t want;
        beat_t held;
        bit    stalled;
        bit    fin;
        logic  rdy;
        int    last_c;
        int    c;
        for (int i = 0; i < int'(NPIX); i++) begin
            want.data = mem[i];
            want.row  = 3'(i / int'(COLS));
            want.col  = 3'(i % int'(COLS));
            want.eol  = ((i % int'(COLS)) == int'(COLS) - 1);
            want.last = (i == int'(NPIX) - 1);
            exp_q.push_back(want);
        end
        nbeats = 0; first_lat = -1; done_lat = -1; ndone = 0; first_data = 0; last_data = 0;
        stalled = 1'b0; held = '0; last_c = -10; c = 0; fin = 1'b0;
        start = 1'b1;
        get_ready(mode, rdy);
        m_ready = rdy;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            act = {m_data, m_row, m_col, m_eol, m_last};
            check("ram_wr", ram_wr, 1);
            check($sformatf("done_c%0d", c), done, (c == last_c + 1));
            check($sformatf("busy_c%0d", c), busy, (done_lat < 0));
            if (done) begin
                ndone++;
                if (done_lat < 0) done_lat = c;
            end
            if (stalled) check("hold", {m_valid, act}, {1'b1, held});
            if (done_lat >= 0 && c > done_lat) check("idle_valid", m_valid, 0);
            if (start_at_done && done) start = 1'b1;
            if (done_lat >= 0 && c >= done_lat + (start_at_done ? 1 : 2)) fin = 1'b1;
            if (!fin) begin
                get_ready(mode, rdy);
                m_ready = rdy;
                if (m_valid && first_lat < 0) first_lat = c;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        want = exp_q.pop_front();
                        check($sformatf("beat%0d", nbeats), act, want);
                    end
                    if (nbeats == 0) first_data = int'($signed(act.data));
                    last_data = int'($signed(act.data));
                    nbeats++;
                    if (nbeats == int'(NPIX)) last_c = c;
                    if (nbeats == sa || nbeats == sb) start = 1'b1;
                    if (nbeats == rst_after) begin
                        @(negedge clk);
                        m_ready = 1'b0;
                        rst_n   = 1'b0;
                        #1;
                        check("rst_valid", m_valid, 0);
                        check("rst_busy", busy, 0);
                        repeat (2) begin
                            @(negedge clk);
                            check("rst_done", {done, m_valid}, 0);
                        end
                        rst_n = 1'b1;
                        fin   = 1'b1;
                    end
                end
                stalled = m_valid && !m_ready;
                held    = act;
            end
            c++;
            if (!fin && c > 4000) begin
                check("frame_timeout", 1, 0);
                fin = 1'b1;
            end
        end
        if (rst_after < 0) check("missing_beats", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs [4];
        int nb, fl, dl, nd, fd, ld;
        vecs[0] = '{0, 0, 64,  -32,  31, 2, 66};
        vecs[1] = '{1, 0, 64,  -32,  31, 2, -1};
        vecs[2] = '{0, 1, 64, -128, 127, 2, 66};
        vecs[3] = '{2, 1, 64, -128, 127, 2, -1};

        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", m_valid, 0);
        check("reset_flags", {m_eol, m_last}, 0);
        check("reset_addr", ram_addr, 0);
        check("reset_data", {m_data, m_row, m_col}, 0);
        check("reset_wr", ram_wr, 1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            fill(vecs[v].pattern);
            run_frame(vecs[v].mode, -1, -1, -1, 1'b0, nb, fl, dl, nd, fd, ld);
            check($sformatf("v%0d_beats", v), nb, vecs[v].exp_beats);
            check($sformatf("v%0d_first", v), fd, vecs[v].exp_first);
            check($sformatf("v%0d_last", v), ld, vecs[v].exp_last);
            check($sformatf("v%0d_first_lat", v), fl, vecs[v].exp_first_lat);
            check($sformatf("v%0d_ndone", v), nd, 1);
            if (vecs[v].exp_done_lat >= 0) check($sformatf("v%0d_done_lat", v), dl, vecs[v].exp_done_lat);
        end

        // Starts mid-frame are ignored; a fresh start afterwards repeats the frame.
        fill(0);
        run_frame(1, 10, 40, -1, 1'b0, nb, fl, dl, nd, fd, ld);
        check("midstart_beats", nb, 64);
        check("midstart_ndone", nd, 1);
        run_frame(0, -1, -1, -1, 1'b0, nb, fl, dl, nd, fd, ld);
        check("second_beats", nb, 64);
        check("second_ndone", nd, 1);

        // Start coincident with done is dropped; start on the following cycle is taken.
        run_frame(0, -1, -1, -1, 1'b1, nb, fl, dl, nd, fd, ld);
        check("atdone_beats", nb, 64);
        run_frame(0, -1, -1, -1, 1'b0, nb, fl, dl, nd, fd, ld);
        check("afterdone_first_lat", fl, 2);
        check("afterdone_beats", nb, 64);

        // Reset in the middle of a frame, then restart from pixel (0,0).
        fill(1);
        run_frame(1, -1, -1, 20, 1'b0, nb, fl, dl, nd, fd, ld);
        check("rstframe_beats", nb, 20);
        check("rstframe_ndone", nd, 0);
        run_frame(2, -1, -1, -1, 1'b0, nb, fl, dl, nd, fd, ld);
        check("restart_first", fd, -128);
        check("restart_beats", nb, 64);

        repeat (4) begin
            fill(2);
            run_frame(2, -1, -1, -1, 1'b0, nb, fl, dl, nd, fd, ld);
            check("rand_beats", nb, 64);
            check("rand_ndone", nd, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
